// File: rtl/scanner.sv
// rtl/scanner.sv - four-digit multiplexed seven-segment scanner for an A+B / A-B calculator.
// Captures operands on each digit advance (unless held) and drives one digit per slot.
module scanner #(
    parameter int unsigned SCAN_DIV = 25000
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       K,
    input  logic       mm1,
    input  logic       mm2,
    input  logic       minus_in,
    output logic [7:0] out,
    output logic [1:0] ctrl,
    output logic       sf_out
);

    localparam int CW = $clog2(SCAN_DIV * 8) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          sf_q, sf_d;
    logic [3:0]    a_q, a_d, b_q, b_d;
    logic          m_q, m_d;

    logic [CW-1:0] slot_len;
    logic          advance;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // >= rather than == so a mode switch that shrinks the slot never strands the counter
    always_comb begin
        slot_len = CW'(SCAN_DIV) << {mm2, mm1};
        advance  = (cnt_q >= (slot_len - CW'(1)));
        cnt_d    = cnt_q + CW'(1);
        ctrl_d   = ctrl_q;
        sf_d     = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        if (advance) begin
            cnt_d  = '0;
            ctrl_d = ctrl_q + 2'd1;
            sf_d   = 1'b1;
            if (!K) begin
                a_d = A;
                b_d = B;
                m_d = minus_in;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            ctrl_q <= 2'd0;
            sf_q   <= 1'b0;
            a_q    <= 4'd0;
            b_q    <= 4'd0;
            m_q    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ctrl_q <= ctrl_d;
            sf_q   <= sf_d;
            a_q    <= a_d;
            b_q    <= b_d;
            m_q    <= m_d;
        end
    end

    logic [4:0] sum, mag, units;
    logic [3:0] diff;
    logic [1:0] tens;
    logic       neg;

    always_comb begin
        sum  = {1'b0, a_q} + {1'b0, b_q};
        diff = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
        neg  = m_q & (a_q < b_q);
        mag  = m_q ? {1'b0, diff} : sum;
        if (mag >= 5'd30) begin
            tens  = 2'd3;
            units = mag - 5'd30;
        end else if (mag >= 5'd20) begin
            tens  = 2'd2;
            units = mag - 5'd20;
        end else if (mag >= 5'd10) begin
            tens  = 2'd1;
            units = mag - 5'd10;
        end else begin
            tens  = 2'd0;
            units = mag;
        end
    end

    always_comb begin
        case (ctrl_q)
            2'd0:    out = {1'b0, hex7(units[3:0])};
            2'd1:    out = {neg, hex7({2'b00, tens})};
            2'd2:    out = {1'b0, hex7(b_q)};
            default: out = {1'b0, hex7(a_q)};
        endcase
    end

    assign ctrl   = ctrl_q;
    assign sf_out = sf_q;

endmodule

// File: tb/tb_scanner.sv
// tb/tb_scanner.sv - directed self-checking bench for scanner.
// Uses a short slot (SCAN_DIV=10) so full frames and mode changes fit in a brief run.
module tb_scanner;

    localparam int DIV = 10;

    logic       clk_sys = 1'b0;
    logic       rst;
    logic [3:0] A, B;
    logic       K, mm1, mm2, minus_in;
    logic [7:0] out;
    logic [1:0] ctrl;
    logic       sf_out;

    int checks = 0;
    int errors = 0;

    scanner #(.SCAN_DIV(DIV)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .K       (K),
        .mm1     (mm1),
        .mm2     (mm2),
        .minus_in(minus_in),
        .out     (out),
        .ctrl    (ctrl),
        .sf_out  (sf_out)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_ctrl(input logic [1:0] c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (ctrl === c) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_adv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (sf_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic edges_to_adv(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            n++;
            if (sf_out === 1'b1) break;
        end
    endtask

    // f[8*c +: 8] holds out while ctrl == c
    task automatic read_frame(output logic [31:0] f, output bit ok);
        bit o;
        ok = 1'b1;
        f  = '0;
        wait_adv(o);
        ok &= o;
        for (int c = 0; c < 4; c++) begin
            wait_ctrl(2'(c), o);
            ok &= o;
            f[8*c +: 8] = out;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; A = 4'd1; B = 4'd1; K = 1'b0;
        mm1 = 1'b0; mm2 = 1'b0; minus_in = 1'b0;
        repeat (3) tick();
        checks++; if (ctrl !== 2'd0) begin errors++; $display("FAIL reset_ctrl got %h want 0", ctrl); end
        checks++; if (sf_out !== 1'b0) begin errors++; $display("FAIL reset_sf got %b want 0", sf_out); end
        checks++; if (out !== 8'h3F) begin errors++; $display("FAIL reset_out got %h want 3F", out); end
    endtask

    task automatic test_first_advance();
        @(negedge clk_sys);
        rst = 1'b0;
        repeat (DIV - 1) tick();
        checks++; if (ctrl !== 2'd0) begin errors++; $display("FAIL pre_adv_ctrl got %h want 0", ctrl); end
        checks++; if (sf_out !== 1'b0) begin errors++; $display("FAIL pre_adv_sf got %b want 0", sf_out); end
        tick();
        checks++; if (ctrl !== 2'd1) begin errors++; $display("FAIL adv_ctrl got %h want 1", ctrl); end
        checks++; if (sf_out !== 1'b1) begin errors++; $display("FAIL adv_sf got %b want 1", sf_out); end
        tick();
        checks++; if (sf_out !== 1'b0) begin errors++; $display("FAIL post_adv_sf got %b want 0", sf_out); end
    endtask

    task automatic test_add();
        logic [31:0] f, exp;
        bit ok;
        exp = 32'h06063F5B;
        read_frame(f, ok);
        checks++; if (!ok) begin errors++; $display("FAIL add_timeout got 0 want 1"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (f[8*i +: 8] !== exp[8*i +: 8]) begin
                errors++; $display("FAIL add_digit%0d got %h want %h", i, f[8*i +: 8], exp[8*i +: 8]);
            end
        end
    endtask

    task automatic test_sub_pos();
        logic [31:0] f, exp;
        bit ok;
        A = 4'd5; B = 4'd2; minus_in = 1'b1;
        exp = 32'h6D5B3F4F;
        read_frame(f, ok);
        checks++; if (!ok) begin errors++; $display("FAIL subpos_timeout got 0 want 1"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (f[8*i +: 8] !== exp[8*i +: 8]) begin
                errors++; $display("FAIL subpos_digit%0d got %h want %h", i, f[8*i +: 8], exp[8*i +: 8]);
            end
        end
    endtask

    task automatic test_sub_neg();
        logic [31:0] f, exp;
        bit ok;
        A = 4'd2; B = 4'd5; minus_in = 1'b1;
        exp = 32'h5B6DBF4F;
        read_frame(f, ok);
        checks++; if (!ok) begin errors++; $display("FAIL subneg_timeout got 0 want 1"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (f[8*i +: 8] !== exp[8*i +: 8]) begin
                errors++; $display("FAIL subneg_digit%0d got %h want %h", i, f[8*i +: 8], exp[8*i +: 8]);
            end
        end
    endtask

    task automatic test_max_hold();
        logic [31:0] f, exp;
        bit ok;
        A = 4'hF; B = 4'hF; minus_in = 1'b0;
        exp = 32'h71714F3F;
        read_frame(f, ok);
        checks++; if (!ok) begin errors++; $display("FAIL max_timeout got 0 want 1"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (f[8*i +: 8] !== exp[8*i +: 8]) begin
                errors++; $display("FAIL max_digit%0d got %h want %h", i, f[8*i +: 8], exp[8*i +: 8]);
            end
        end
        K = 1'b1; A = 4'd0; B = 4'd3; minus_in = 1'b1;
        for (int fr = 0; fr < 2; fr++) begin
            read_frame(f, ok);
            checks++;
            if (!ok || f !== exp) begin
                errors++; $display("FAIL hold_frame%0d got %h want %h", fr, f, exp);
            end
        end
        K = 1'b0; A = 4'hF; B = 4'hF; minus_in = 1'b0;
    endtask

    task automatic test_mode();
        bit ok;
        int n;
        logic [1:0] c0;
        mm2 = 1'b1; mm1 = 1'b1;
        wait_adv(ok);
        edges_to_adv(n);
        checks++; if (n !== 8 * DIV) begin errors++; $display("FAIL mode11_slot got %0d want %0d", n, 8 * DIV); end
        repeat (7 * DIV) tick();
        c0 = ctrl;
        checks++; if (sf_out !== 1'b0) begin errors++; $display("FAIL mode_mid_sf got %b want 0", sf_out); end
        mm2 = 1'b0; mm1 = 1'b0;
        tick();
        checks++; if (sf_out !== 1'b1) begin errors++; $display("FAIL shrink_adv_sf got %b want 1", sf_out); end
        checks++;
        if (ctrl !== 2'(c0 + 2'd1)) begin
            errors++; $display("FAIL shrink_adv_ctrl got %h want %h", ctrl, 2'(c0 + 2'd1));
        end
        edges_to_adv(n);
        checks++; if (n !== DIV) begin errors++; $display("FAIL mode00_slot got %0d want %0d", n, DIV); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int n;
        wait_ctrl(2'd2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL areset_wait got 0 want 1"); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (ctrl !== 2'd0) begin errors++; $display("FAIL areset_ctrl got %h want 0", ctrl); end
        checks++; if (sf_out !== 1'b0) begin errors++; $display("FAIL areset_sf got %b want 0", sf_out); end
        checks++; if (out !== 8'h3F) begin errors++; $display("FAIL areset_out got %h want 3F", out); end
        @(negedge clk_sys);
        rst = 1'b0;
        edges_to_adv(n);
        checks++; if (n !== DIV) begin errors++; $display("FAIL areset_first_adv got %0d want %0d", n, DIV); end
    endtask

    initial begin
        test_reset();
        test_first_advance();
        test_add();
        test_sub_pos();
        test_sub_neg();
        test_max_hold();
        test_mode();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scanner.md
SCANNER -- requirements
Module: scanner

Interface
REQ-001 Parameter SCAN_DIV, default 25000, clk_sys cycles per digit slot at mode 00 (1 ms at 25 MHz).
REQ-002 clk_sys  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 A  input  4  operand A, unsigned 0..15.
REQ-005 B  input  4  operand B, unsigned 0..15.
REQ-006 K  input  1  hold: 1 freezes captured operands; 0 tracks inputs.
REQ-007 mm1  input  1  scan-rate mode bit 0.
REQ-008 mm2  input  1  scan-rate mode bit 1.
REQ-009 minus_in  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-010 out  output  8  segment pattern {dp,g,f,e,d,c,b,a}, active-high (common cathode).
REQ-011 ctrl  output  2  index of the currently driven digit, 0..3.
REQ-012 sf_out  output  1  scan strobe, one-cycle pulse on each digit advance.

Function
REQ-013 Slot length L = SCAN_DIV << {mm2,mm1}: 00 -> 1x, 01 -> 2x, 10 -> 4x, 11 -> 8x.
REQ-014 Divider counter counts 0..L-1; when count >= L-1 it returns to 0 and ctrl increments modulo 4 (3 -> 0 wraps).
REQ-015 A mode change that shrinks L below the current count SHALL cause an advance on the next edge (>= compare); no lock-up.
REQ-016 sf_out SHALL be 1 exactly in the cycle after the edge on which ctrl advanced, 0 otherwise.
REQ-017 On each advance edge with K=0, registers Ar, Br, Mr capture A, B, minus_in; with K=1 they hold.
REQ-018 Result R = Ar+Br (0..30) when Mr=0; R = Ar-Br signed (-15..15) when Mr=1; magnitude |R|, negative flag N = Mr and Ar<Br.
REQ-019 Digit map (out is combinational from ctrl and captured registers): ctrl=0 -> units of |R|; ctrl=1 -> tens of |R| (0..3) with dp = N; ctrl=2 -> Br as hex; ctrl=3 -> Ar as hex.
REQ-020 dp SHALL be 0 on all digits except ctrl=1 with N=1.
REQ-021 Hex codes (g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-022 Tens digit SHALL be shown even when 0 (no leading-zero blanking).
REQ-023 Operand changes between advances SHALL NOT affect out until the next advance with K=0.

Reset
REQ-024 While rst=1: counter=0, ctrl=0, sf_out=0, Ar=Br=0, Mr=0; out therefore 8'h3F.
REQ-025 Reset asserted mid-slot SHALL clear immediately (asynchronously); first advance occurs L cycles after rst deasserts.

Verification
REQ-026 Reset release, mode 00, A=1 B=1 minus_in=0 K=0 -> ctrl 0->1 after 25000 cycles with sf_out pulse; after one full frame: ctrl0=5B, ctrl1=3F, ctrl2=06, ctrl3=06.
REQ-027 A=5 B=2 minus_in=1 -> after capture: ctrl0=4F, ctrl1=3F (dp 0), ctrl2=5B, ctrl3=6D.
REQ-028 A=2 B=5 minus_in=1 -> ctrl0=4F, ctrl1=BF (dp lit, negative), ctrl2=6D, ctrl3=5B.
REQ-029 A=F B=F minus_in=0 -> R=30: ctrl0=3F, ctrl1=4F, ctrl2=71, ctrl3=71; then K=1, A=0 -> display unchanged over 2 frames.
REQ-030 {mm2,mm1}=11 -> advances every 200000 cycles; switch to 00 when count >150000 -> advance on next edge, then 25000-cycle slots.
REQ-031 rst pulse mid-frame at ctrl=2 -> ctrl=0, sf_out=0, out=3F immediately, without waiting for a clock edge.
